// File: rtl/exec_pkg.sv
// Shared execute-stage constants: datapath widths, RV32I function codes and ALU op encoding.
package exec_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

endpackage

// File: rtl/ex_stage_alu.sv
// Purely combinational RV32I integer ALU; wrap-around arithmetic, shift amount from b_i[4:0].
module ex_stage_alu
    import exec_pkg::*;
(
    input  alu_op_e          op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    output logic [XLEN-1:0]  result_o
);

    logic [4:0] shamt;

    always_comb begin
        result_o = '0;
        shamt    = b_i[4:0];
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Two-register execute stage: S1 (ID/EX) feeds the ALU, S2 (EX/WB) holds the result,
// with forwarding from S2 back into S1 operands and valid/ready backpressure.
module ex_stage
    import exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic [6:0]        in_funct7,
    input  logic [2:0]        in_funct3,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wen,
    output logic              out_illegal
);

    logic              s1_valid_q, s1_valid_d;
    logic [XLEN-1:0]   s1_rs1_data_q, s1_rs2_data_q, s1_imm_q;
    logic [REG_AW-1:0] s1_rs1_addr_q, s1_rs2_addr_q, s1_rd_q;
    logic              s1_use_imm_q, s1_wen_q;
    logic [6:0]        s1_funct7_q;
    logic [2:0]        s1_funct3_q;

    logic              s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]   s2_result_q;
    logic [REG_AW-1:0] s2_rd_q;
    logic              s2_wen_q, s2_illegal_q;

    logic              s2_load, accept, fwd_ok, legal;
    logic [6:0]        funct7_eff;
    alu_op_e           alu_op;
    logic [XLEN-1:0]   op_a, op_b, alu_result;

    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    // rst is folded in so in_ready stays low for the whole reset interval
    assign in_ready = !rst && !flush && (!s1_valid_q || s2_load);
    assign accept   = in_valid && in_ready;

    // ---------------- operand select and forwarding ----------------
    assign fwd_ok = s2_valid_q && s2_wen_q && (s2_rd_q != '0);

    always_comb begin
        op_a = s1_rs1_data_q;
        op_b = s1_use_imm_q ? s1_imm_q : s1_rs2_data_q;
        if (fwd_ok && (s2_rd_q == s1_rs1_addr_q)) begin
            op_a = s2_result_q;
        end
        if (fwd_ok && !s1_use_imm_q && (s2_rd_q == s1_rs2_addr_q)) begin
            op_b = s2_result_q;
        end
    end

    // ---------------- function decode and legality ----------------
    always_comb begin
        funct7_eff = s1_funct7_q;
        legal      = 1'b1;
        alu_op     = ALU_ADD;
        // I-type immediates reuse the funct7 bits; only SRLI/SRAI carry a real funct7
        if (s1_use_imm_q && (s1_funct3_q != F3_SR)) begin
            funct7_eff = FUNCT7_BASE;
        end
        if (funct7_eff == FUNCT7_BASE) begin
            case (s1_funct3_q)
                F3_ADD:  alu_op = ALU_ADD;
                F3_SLL:  alu_op = ALU_SLL;
                F3_SLT:  alu_op = ALU_SLT;
                F3_SLTU: alu_op = ALU_SLTU;
                F3_XOR:  alu_op = ALU_XOR;
                F3_SR:   alu_op = ALU_SRL;
                F3_OR:   alu_op = ALU_OR;
                F3_AND:  alu_op = ALU_AND;
                default: alu_op = ALU_ADD;
            endcase
        end else if (funct7_eff == FUNCT7_ALT) begin
            case (s1_funct3_q)
                F3_ADD:  alu_op = ALU_SUB;
                F3_SR:   alu_op = ALU_SRA;
                default: legal  = 1'b0;
            endcase
        end else begin
            legal = 1'b0;
        end
    end

    ex_stage_alu u_alu (
        .op_i     (alu_op),
        .a_i      (op_a),
        .b_i      (op_b),
        .result_o (alu_result)
    );

    // ---------------- S1 register ----------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_rs1_data_q <= '0;
            s1_rs2_data_q <= '0;
            s1_rs1_addr_q <= '0;
            s1_rs2_addr_q <= '0;
            s1_imm_q      <= '0;
            s1_use_imm_q  <= 1'b0;
            s1_funct7_q   <= '0;
            s1_funct3_q   <= '0;
            s1_rd_q       <= '0;
            s1_wen_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_rs1_data_q <= in_rs1_data;
                s1_rs2_data_q <= in_rs2_data;
                s1_rs1_addr_q <= in_rs1_addr;
                s1_rs2_addr_q <= in_rs2_addr;
                s1_imm_q      <= in_imm;
                s1_use_imm_q  <= in_use_imm;
                s1_funct7_q   <= in_funct7;
                s1_funct3_q   <= in_funct3;
                s1_rd_q       <= in_rd;
                s1_wen_q      <= in_wen;
            end
        end
    end

    // ---------------- S2 register (unaffected by flush) ----------------
    always_comb begin
        s2_valid_d = s2_valid_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_rd_q      <= '0;
            s2_wen_q     <= 1'b0;
            s2_illegal_q <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                s2_result_q  <= legal ? alu_result : '0;
                s2_rd_q      <= s1_rd_q;
                s2_wen_q     <= s1_wen_q && legal;
                s2_illegal_q <= !legal;
            end
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_rd      = s2_rd_q;
    assign out_wen     = s2_wen_q;
    assign out_illegal = s2_illegal_q;

endmodule
